// File: rtl/riscv32ima_pkg.sv
// Shared definitions for the RV32IMA writeback stage.
//   LOAD_* : funct3 encodings of the integer load instructions.
//   wb_state_t : writeback FSM states.
//   DEF_REG_* : default GPR index / data widths.
package riscv32ima_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_REG_DATA_WIDTH = 32;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LW  = 3'd2;
  localparam logic [2:0] LOAD_LBU = 3'd4;
  localparam logic [2:0] LOAD_LHU = 3'd5;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/riscv32ima_load_align.sv
// Combinational load formatter and legality checker.
// Ports:
//   funct3_i     load size/sign encoding
//   addr_lo_i    byte offset of the load address within the word
//   word_i       word-aligned read data
//   value_o      extracted, sign/zero-extended load value
//   misaligned_o halfword on odd offset, or word on nonzero offset
//   illegal_o    funct3 is not a defined load (3, 6, 7)
module riscv32ima_load_align
  import riscv32ima_pkg::*;
#(
  parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH
) (
  input  logic [2:0]                funct3_i,
  input  logic [1:0]                addr_lo_i,
  input  logic [REG_DATA_WIDTH-1:0] word_i,
  output logic [REG_DATA_WIDTH-1:0] value_o,
  output logic                      misaligned_o,
  output logic                      illegal_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_s = word_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    value_o = word_i;
    case (funct3_i)
      LOAD_LB:  value_o = {{(REG_DATA_WIDTH-8){byte_s[7]}}, byte_s};
      LOAD_LH:  value_o = {{(REG_DATA_WIDTH-16){half_s[15]}}, half_s};
      LOAD_LBU: value_o = {{(REG_DATA_WIDTH-8){1'b0}}, byte_s};
      LOAD_LHU: value_o = {{(REG_DATA_WIDTH-16){1'b0}}, half_s};
      default:  value_o = word_i;
    endcase
  end

  assign misaligned_o = (((funct3_i == LOAD_LH) || (funct3_i == LOAD_LHU)) && addr_lo_i[0])
                      || ((funct3_i == LOAD_LW) && (addr_lo_i != 2'b00));

  assign illegal_o = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);

endmodule

// File: rtl/riscv32ima_wback.sv
// Writeback stage: sole driver of the GPR write port.
// Takes retiring ops from EX/MEM, formats load data from the memory
// response, and issues one registered GPR write per op.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ex_valid/ex_ready                 op handshake from EX/MEM
//   ex_is_load, ex_wen, ex_rd,
//   ex_funct3, ex_addr_lo, ex_result  op description
//   mem_rsp_valid/data/err            data memory response
//   wback_reg_wen/addr/data           registered GPR write (also the bypass source)
//   load_pending, pending_rd          outstanding load info for decode stalls
//   load_fault                        one-cycle fault pulse
module riscv32ima_wback
  import riscv32ima_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic                      ex_is_load,
  input  logic                      ex_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [2:0]                ex_funct3,
  input  logic [1:0]                ex_addr_lo,
  input  logic [REG_DATA_WIDTH-1:0] ex_result,
  input  logic                      mem_rsp_valid,
  input  logic [REG_DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                      mem_rsp_err,
  output logic                      wback_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
  output logic [REG_DATA_WIDTH-1:0] wback_reg_data,
  output logic                      load_pending,
  output logic [REG_ADDR_WIDTH-1:0] pending_rd,
  output logic                      load_fault
);

  wb_state_t                 state_q, state_d;
  logic                      wen_q, wen_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_DATA_WIDTH-1:0] data_q, data_d;
  logic                      fault_q, fault_d;
  logic [REG_ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]                ld_f3_q, ld_f3_d;
  logic [1:0]                ld_lo_q, ld_lo_d;
  logic                      ld_wen_q, ld_wen_d;

  logic                      accept;
  logic [2:0]                al_f3;
  logic [1:0]                al_lo;
  logic [REG_DATA_WIDTH-1:0] al_value;
  logic                      al_misaligned;
  logic                      al_illegal;

  assign ex_ready = (state_q == IDLE) && !rst;
  assign accept   = ex_valid && ex_ready;

  // One formatter serves both phases: in IDLE it checks the incoming load's
  // legality, in WAIT_MEM it formats the response using the latched fields.
  assign al_f3 = (state_q == IDLE) ? ex_funct3  : ld_f3_q;
  assign al_lo = (state_q == IDLE) ? ex_addr_lo : ld_lo_q;

  riscv32ima_load_align #(
    .REG_DATA_WIDTH(REG_DATA_WIDTH)
  ) u_align (
    .funct3_i    (al_f3),
    .addr_lo_i   (al_lo),
    .word_i      (mem_rsp_data),
    .value_o     (al_value),
    .misaligned_o(al_misaligned),
    .illegal_o   (al_illegal)
  );

  always_comb begin
    state_d  = state_q;
    wen_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    fault_d  = 1'b0;
    ld_rd_d  = ld_rd_q;
    ld_f3_d  = ld_f3_q;
    ld_lo_d  = ld_lo_q;
    ld_wen_d = ld_wen_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!ex_is_load) begin
            // Address/data only move on a real write so the bypass view holds.
            if (ex_wen && (ex_rd != '0)) begin
              wen_d  = 1'b1;
              addr_d = ex_rd;
              data_d = ex_result;
            end
          end else if (al_misaligned || al_illegal) begin
            fault_d = 1'b1;
          end else begin
            state_d  = WAIT_MEM;
            ld_rd_d  = ex_rd;
            ld_f3_d  = ex_funct3;
            ld_lo_d  = ex_addr_lo;
            ld_wen_d = ex_wen;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          if (mem_rsp_err) begin
            fault_d = 1'b1;
          end else if (ld_wen_q && (ld_rd_q != '0)) begin
            wen_d  = 1'b1;
            addr_d = ld_rd_q;
            data_d = al_value;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      fault_q  <= 1'b0;
      ld_rd_q  <= '0;
      ld_f3_q  <= 3'd0;
      ld_lo_q  <= 2'd0;
      ld_wen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
      ld_rd_q  <= ld_rd_d;
      ld_f3_q  <= ld_f3_d;
      ld_lo_q  <= ld_lo_d;
      ld_wen_q <= ld_wen_d;
    end
  end

  assign wback_reg_wen  = wen_q;
  assign wback_reg_addr = addr_q;
  assign wback_reg_data = data_q;
  assign load_fault     = fault_q;
  assign load_pending   = (state_q == WAIT_MEM);
  assign pending_rd     = ld_rd_q;

endmodule

// File: tb/tb_riscv32ima_wback.sv
module tb_riscv32ima_wback;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic        ex_wen;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic [31:0] ex_result;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        wback_reg_wen;
  logic [4:0]  wback_reg_addr;
  logic [31:0] wback_reg_data;
  logic        load_pending;
  logic [4:0]  pending_rd;
  logic        load_fault;

  riscv32ima_wback dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_is_load    (ex_is_load),
    .ex_wen        (ex_wen),
    .ex_rd         (ex_rd),
    .ex_funct3     (ex_funct3),
    .ex_addr_lo    (ex_addr_lo),
    .ex_result     (ex_result),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .wback_reg_wen (wback_reg_wen),
    .wback_reg_addr(wback_reg_addr),
    .wback_reg_data(wback_reg_data),
    .load_pending  (load_pending),
    .pending_rd    (pending_rd),
    .load_fault    (load_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: at most one outstanding load, described as a record.
  bit          m_busy;
  logic [4:0]  m_prd;
  logic [2:0]  m_pf3;
  logic [1:0]  m_plo;
  bit          m_pwen;
  bit          e_wen;
  bit          e_fault;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] load_value(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [31:0] s;
    s = w >> (8 * int'(lo));
    case (f3)
      3'd0: return {{24{s[7]}}, s[7:0]};
      3'd1: return {{16{s[15]}}, s[15:0]};
      3'd4: return {24'd0, s[7:0]};
      3'd5: return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic bit load_bad(input logic [2:0] f3, input logic [1:0] lo);
    int nbytes;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    nbytes = 1 << int'(f3[1:0]);
    return (int'(lo) % nbytes) != 0;
  endfunction

  // Advance one clock: predict from the inputs now applied, then compare.
  task automatic step();
    e_wen   = 1'b0;
    e_fault = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_prd  = 5'd0;
      e_addr = 5'd0;
      e_data = 32'd0;
    end else if (!m_busy) begin
      if (ex_valid) begin
        if (!ex_is_load) begin
          if (ex_wen && ex_rd != 5'd0) begin
            e_wen = 1'b1; e_addr = ex_rd; e_data = ex_result;
          end
        end else if (load_bad(ex_funct3, ex_addr_lo)) begin
          e_fault = 1'b1;
        end else begin
          m_busy = 1'b1; m_prd = ex_rd; m_pf3 = ex_funct3; m_plo = ex_addr_lo; m_pwen = ex_wen;
        end
      end
    end else if (mem_rsp_valid) begin
      m_busy = 1'b0;
      if (mem_rsp_err) e_fault = 1'b1;
      else if (m_pwen && m_prd != 5'd0) begin
        e_wen = 1'b1; e_addr = m_prd; e_data = load_value(mem_rsp_data, m_pf3, m_plo);
      end
    end
    @(posedge clk);
    #1;
    chk("wen",   32'(wback_reg_wen),  32'(e_wen));
    chk("addr",  32'(wback_reg_addr), 32'(e_addr));
    chk("data",  wback_reg_data,      e_data);
    chk("fault", 32'(load_fault),     32'(e_fault));
    chk("pend",  32'(load_pending),   32'(m_busy));
    chk("ready", 32'(ex_ready),       32'(!m_busy && !rst));
    if (m_busy) chk("pend_rd", 32'(pending_rd), 32'(m_prd));
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_wen = 1'b0; ex_rd = 5'd0;
    ex_funct3 = 3'd0; ex_addr_lo = 2'd0; ex_result = 32'd0;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; mem_rsp_err = 1'b0;
  endtask

  task automatic op(input bit ld, input bit wen, input logic [4:0] rd, input logic [2:0] f3,
                    input logic [1:0] lo, input logic [31:0] res);
    idle_in();
    ex_valid = 1'b1; ex_is_load = ld; ex_wen = wen; ex_rd = rd;
    ex_funct3 = f3; ex_addr_lo = lo; ex_result = res;
  endtask

  task automatic rsp(input logic [31:0] d, input bit err);
    idle_in();
    mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_err = err;
  endtask

  initial begin
    m_busy = 0; m_prd = 0; m_pf3 = 0; m_plo = 0; m_pwen = 0;
    e_wen = 0; e_fault = 0; e_addr = 0; e_data = 0;
    idle_in();
    rst = 1'b1;
    step();
    step();
    chk("rst_wen", 32'(wback_reg_wen), 32'd0);
    chk("rst_ready", 32'(ex_ready), 32'd0);
    rst = 1'b0;
    step();

    // ALU write, then rd=0
    op(0, 1, 5'd5, 3'd0, 2'd0, 32'h1234_5678);
    step();
    chk("alu_wen", 32'(wback_reg_wen), 32'd1);
    chk("alu_addr", 32'(wback_reg_addr), 32'd5);
    chk("alu_data", wback_reg_data, 32'h1234_5678);
    op(0, 1, 5'd0, 3'd0, 2'd0, 32'hDEAD_BEEF);
    step();
    chk("x0_wen", 32'(wback_reg_wen), 32'd0);
    chk("x0_hold", wback_reg_data, 32'h1234_5678);
    idle_in();
    step();

    // Load formatting
    op(1, 1, 5'd3, 3'd0, 2'd3, 32'd0); step();
    rsp(32'h80FF_FF7F, 0); step();
    chk("lb_data", wback_reg_data, 32'hFFFF_FF80);
    op(1, 1, 5'd3, 3'd4, 2'd3, 32'd0); step();
    rsp(32'h80FF_FF7F, 0); step();
    chk("lbu_data", wback_reg_data, 32'h0000_0080);
    op(1, 1, 5'd3, 3'd5, 2'd2, 32'd0); step();
    rsp(32'h80FF_FF7F, 0); step();
    chk("lhu_data", wback_reg_data, 32'h0000_80FF);

    // LW with 4-cycle memory latency, then an ALU op right after
    op(1, 1, 5'd7, 3'd2, 2'd0, 32'd0); step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      chk("lw_pend", 32'(load_pending), 32'd1);
      chk("lw_prd", 32'(pending_rd), 32'd7);
      chk("lw_ready", 32'(ex_ready), 32'd0);
      step();
    end
    chk("lw_pend4", 32'(load_pending), 32'd1);
    rsp(32'hCAFE_F00D, 0); step();
    chk("lw_wen", 32'(wback_reg_wen), 32'd1);
    chk("lw_addr", 32'(wback_reg_addr), 32'd7);
    chk("lw_data", wback_reg_data, 32'hCAFE_F00D);
    chk("lw_ready_after", 32'(ex_ready), 32'd1);
    op(0, 1, 5'd9, 3'd0, 2'd0, 32'h0000_0042); step();
    chk("after_lw_alu", wback_reg_data, 32'h0000_0042);

    // Faults
    op(1, 1, 5'd4, 3'd2, 2'd2, 32'd0); step();
    chk("mis_fault", 32'(load_fault), 32'd1);
    chk("mis_pend", 32'(load_pending), 32'd0);
    op(1, 1, 5'd4, 3'd2, 2'd0, 32'd0); step();
    rsp(32'h1111_1111, 1); step();
    chk("err_fault", 32'(load_fault), 32'd1);
    chk("err_wen", 32'(wback_reg_wen), 32'd0);

    // Reset in the middle of a load, late response afterwards
    op(1, 1, 5'd9, 3'd2, 2'd0, 32'd0); step();
    idle_in(); rst = 1'b1; step();
    chk("mid_rst_data", wback_reg_data, 32'd0);
    chk("mid_rst_pend", 32'(load_pending), 32'd0);
    rst = 1'b0; step();
    rsp(32'h5555_AAAA, 0); step();
    chk("late_wen", 32'(wback_reg_wen), 32'd0);
    chk("late_fault", 32'(load_fault), 32'd0);

    // Stray response in IDLE, then an illegal funct3
    rsp(32'h7777_7777, 0); step();
    chk("stray_fault", 32'(load_fault), 32'd0);
    op(1, 1, 5'd6, 3'd3, 2'd0, 32'd0); step();
    chk("f3_fault", 32'(load_fault), 32'd1);
    chk("f3_wen", 32'(wback_reg_wen), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle_in();
      rst           = ($urandom_range(99) < 2);
      ex_valid      = ($urandom_range(99) < 55);
      ex_is_load    = ($urandom_range(99) < 45);
      ex_wen        = ($urandom_range(99) < 85);
      ex_rd         = 5'($urandom);
      ex_funct3     = ($urandom_range(99) < 80) ? 3'($urandom_range(2)) | (3'($urandom_range(1)) << 2)
                                                : 3'($urandom);
      ex_addr_lo    = 2'($urandom);
      ex_result     = $urandom;
      mem_rsp_valid = ($urandom_range(99) < 35);
      mem_rsp_data  = $urandom;
      mem_rsp_err   = ($urandom_range(99) < 10);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
